// File: rtl/wb_master_bridge_if.sv
// Request/response handshake and Wishbone master bus bundle for wb_master_bridge.
//   master modport : bridge side (accepts requests, drives Wishbone, returns responses)
//   slave modport  : environment side (issues requests, models the Wishbone slave,
//                    consumes responses)
// Signals:
//   req_valid/req_ready/req_we/req_adr/req_dat/req_sel : command port
//   rsp_valid/rsp_ready/rsp_dat/rsp_err                : response port
//   wbm_cyc_o/wbm_stb_o/wbm_we_o/wbm_sel_o/wbm_adr_o/wbm_dat_o/wbm_dat_i/wbm_ack_i : Wishbone
interface wb_master_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  req_valid, req_we, req_adr, req_dat, req_sel,
    output req_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output req_valid, req_we, req_adr, req_dat, req_sel,
    input  req_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-cycle master. Takes one read/write command from the
// request port, runs exactly one Wishbone cycle (ACK or timeout), and returns
// the result on the response port.
// Ports:
//   wb_clk_i  : clock, rising edge
//   wb_rst_i  : asynchronous active-high reset
//   bus       : wb_master_bridge_if.master (request, response, Wishbone signals)
//   txn_count : responses delivered without error, wraps
//   err_count : timeout responses delivered, saturates at 255
module wb_master_bridge #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_master_bridge_if.master   bus,
  output logic [CNT_W-1:0]     txn_count,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  // Only combinational output: a command may be taken whenever the FSM is idle.
  assign bus.req_ready = (state == IDLE);

  // CYC and STB share one register so they can never diverge.
  assign bus.wbm_cyc_o = cyc;
  assign bus.wbm_stb_o = cyc;
  assign bus.wbm_we_o  = we;
  assign bus.wbm_sel_o = sel;
  assign bus.wbm_adr_o = adr;
  assign bus.wbm_dat_o = dat_o;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_dat   = rsp_dat;
  assign bus.rsp_err   = rsp_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      cyc       <= 1'b0;
      we        <= 1'b0;
      sel       <= '0;
      adr       <= '0;
      dat_o     <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      txn_count <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            // Command fields go straight onto the bus and stay put until the cycle ends.
            we      <= bus.req_we;
            sel     <= bus.req_sel;
            adr     <= bus.req_adr;
            dat_o   <= bus.req_dat;
            cyc     <= 1'b1;
            tmo_cnt <= '0;
            state   <= BUS;
          end
        end

        BUS: begin
          // ACK wins over the timeout, so an ACK in the last allowed cycle succeeds.
          if (bus.wbm_ack_i) begin
            cyc       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_dat   <= we ? 32'd0 : bus.wbm_dat_i;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            cyc       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_dat   <= 32'd0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_dat   <= 32'd0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
            if (rsp_err) begin
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else begin
              txn_count <= txn_count + CNT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
module tb_wb_master_bridge;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] txn_count;
  logic [7:0]       err_count;
  int               tests = 0;
  int               fails = 0;

  wb_master_bridge_if bus();

  wb_master_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .txn_count (txn_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and play the Wishbone slave. ack_after = number of
  // wait cycles before ACK (-1 = never). Returns in the cycle after STB drops.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int ack_after, input logic [31:0] rdat,
                         output int stb_cycles, output bit stable_ok);
    bus.req_valid = 1'b1; bus.req_we = w; bus.req_adr = a; bus.req_dat = d; bus.req_sel = s;
    tick();
    bus.req_valid = 1'b0;
    stb_cycles = 0;
    stable_ok  = 1'b1;
    while (bus.wbm_stb_o === 1'b1 && stb_cycles < 100) begin
      stb_cycles++;
      if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_we_o !== w || bus.wbm_adr_o !== a ||
          bus.wbm_sel_o !== s || (w && bus.wbm_dat_o !== d)) stable_ok = 1'b0;
      if (stb_cycles == ack_after + 1) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = rdat;
      end
      tick();
      bus.wbm_ack_i = 1'b0;
    end
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    tests++; if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, bus.rsp_err} !== 4'b0) begin fails++; $display("FAIL reset_ctrl: got %b want 0000", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, bus.rsp_err}); end
    tests++; if ({bus.wbm_adr_o, bus.rsp_dat} !== 64'd0) begin fails++; $display("FAIL reset_data: got %h want 0", {bus.wbm_adr_o, bus.rsp_dat}); end
    tests++; if (txn_count !== '0 || err_count !== 8'd0) begin fails++; $display("FAIL reset_counters: got %0d/%0d want 0/0", txn_count, err_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    int n; bit ok;
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, n, ok);
    tests++; if (n !== 1) begin fails++; $display("FAIL read_stb_cycles: got %0d want 1", n); end
    tests++; if (!ok) begin fails++; $display("FAIL read_bus_fields: got unstable want stable"); end
    tests++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL read_rsp_latency: got rsp_valid=%b want 1", bus.rsp_valid); end
    tests++; if (bus.rsp_dat !== 32'hDEAD_BEEF) begin fails++; $display("FAIL read_rsp_dat: got %h want deadbeef", bus.rsp_dat); end
    tests++; if (bus.rsp_err !== 1'b0) begin fails++; $display("FAIL read_rsp_err: got %b want 0", bus.rsp_err); end
    take_rsp();
    tests++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin fails++; $display("FAIL read_after_handshake: got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
    tests++; if (txn_count !== 8'd1) begin fails++; $display("FAIL read_txn_count: got %0d want 1", txn_count); end
  endtask

  task automatic test_write();
    int n; bit ok;
    run_txn(1'b1, 32'h3000_0010, 32'h1234_5678, 4'h3, 5, 32'hFFFF_FFFF, n, ok);
    tests++; if (n !== 6) begin fails++; $display("FAIL write_stb_cycles: got %0d want 6", n); end
    tests++; if (!ok) begin fails++; $display("FAIL write_bus_stable: got unstable want stable"); end
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'd0 || bus.rsp_err !== 1'b0) begin fails++; $display("FAIL write_rsp: got v=%b dat=%h err=%b want 1/0/0", bus.rsp_valid, bus.rsp_dat, bus.rsp_err); end
    take_rsp();
    tests++; if (txn_count !== 8'd2) begin fails++; $display("FAIL write_txn_count: got %0d want 2", txn_count); end
  endtask

  task automatic test_timeout();
    int n; bit ok;
    run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, -1, 32'h0, n, ok);
    tests++; if (n !== 16) begin fails++; $display("FAIL tmo_stb_cycles: got %0d want 16", n); end
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_dat !== 32'd0) begin fails++; $display("FAIL tmo_rsp: got v=%b err=%b dat=%h want 1/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_dat); end
    take_rsp();
    tests++; if (err_count !== 8'd1 || txn_count !== 8'd2) begin fails++; $display("FAIL tmo_counters: got err=%0d txn=%0d want 1/2", err_count, txn_count); end
    run_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 15, 32'hA5A5_0001, n, ok);
    tests++; if (n !== 16) begin fails++; $display("FAIL late_ack_stb_cycles: got %0d want 16", n); end
    tests++; if (bus.rsp_err !== 1'b0 || bus.rsp_dat !== 32'hA5A5_0001) begin fails++; $display("FAIL late_ack_rsp: got err=%b dat=%h want 0/a5a50001", bus.rsp_err, bus.rsp_dat); end
    take_rsp();
    tests++; if (txn_count !== 8'd3 || err_count !== 8'd1) begin fails++; $display("FAIL late_ack_counters: got txn=%0d err=%0d want 3/1", txn_count, err_count); end
  endtask

  task automatic test_back_to_back();
    int n; bit ok; bit held;
    run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 0, 32'h5555_AAAA, n, ok);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_adr = 32'h3000_0034; bus.req_sel = 4'h1;
    bus.wbm_dat_i = 32'h0BAD_0BAD;
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'h5555_AAAA || bus.rsp_err !== 1'b0 ||
          bus.req_ready !== 1'b0 || bus.wbm_cyc_o !== 1'b0) held = 1'b0;
      tick();
    end
    tests++; if (!held) begin fails++; $display("FAIL bp_hold: got fields changed or new cycle want held"); end
    take_rsp();
    tests++; if (bus.req_ready !== 1'b1 || bus.wbm_cyc_o !== 1'b0) begin fails++; $display("FAIL bp_idle_after: got ready=%b cyc=%b want 1/0", bus.req_ready, bus.wbm_cyc_o); end
    tick();
    tests++; if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== 32'h3000_0034) begin fails++; $display("FAIL bp_next_accept: got cyc=%b adr=%h want 1/30000034", bus.wbm_cyc_o, bus.wbm_adr_o); end
    bus.req_valid = 1'b0;
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'h0000_0077;
    tick();
    bus.wbm_ack_i = 1'b0;
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'h0000_0077) begin fails++; $display("FAIL bp_second_rsp: got v=%b dat=%h want 1/00000077", bus.rsp_valid, bus.rsp_dat); end
    take_rsp();
    tests++; if (txn_count !== 8'd5) begin fails++; $display("FAIL bp_txn_count: got %0d want 5", txn_count); end
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_adr = 32'h3000_0040; bus.req_sel = 4'hF;
    tick();
    bus.req_valid = 1'b0;
    tests++; if (bus.wbm_stb_o !== 1'b1) begin fails++; $display("FAIL rstmid_stb_before: got %b want 1", bus.wbm_stb_o); end
    #2 rst = 1'b1;
    #1;
    tests++; if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.req_ready !== 1'b1) begin fails++; $display("FAIL rstmid_async: got cyc=%b stb=%b ready=%b want 0/0/1", bus.wbm_cyc_o, bus.wbm_stb_o, bus.req_ready); end
    tests++; if (txn_count !== '0 || err_count !== 8'd0) begin fails++; $display("FAIL rstmid_counters: got %0d/%0d want 0/0", txn_count, err_count); end
    tick();
    rst = 1'b0;
    tick();
    run_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 2, 32'hC0DE_0001, n, ok);
    tests++; if (n !== 3 || bus.rsp_dat !== 32'hC0DE_0001 || bus.rsp_err !== 1'b0) begin fails++; $display("FAIL rstmid_read_after: got n=%0d dat=%h err=%b want 3/c0de0001/0", n, bus.rsp_dat, bus.rsp_err); end
    take_rsp();
    tests++; if (txn_count !== 8'd1) begin fails++; $display("FAIL rstmid_txn_count: got %0d want 1", txn_count); end
  endtask

  task automatic test_counters();
    int n; bit ok; bit quiet;
    // Stray ACKs while idle.
    quiet = 1'b1;
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.req_ready !== 1'b1 || bus.wbm_cyc_o !== 1'b0 || bus.rsp_valid !== 1'b0) quiet = 1'b0;
    end
    bus.wbm_ack_i = 1'b0;
    tests++; if (!quiet) begin fails++; $display("FAIL stray_ack_state: got state disturbed want idle"); end
    tests++; if (txn_count !== 8'd1 || err_count !== 8'd0) begin fails++; $display("FAIL stray_ack_counters: got %0d/%0d want 1/0", txn_count, err_count); end
    // Fresh start for the wrap check.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < 257; i++) begin
      run_txn(1'b0, 32'h3000_0100, 32'h0, 4'hF, 0, 32'h1, n, ok);
      take_rsp();
    end
    tests++; if (txn_count !== 8'd1) begin fails++; $display("FAIL txn_wrap: got %0d want 1", txn_count); end
    for (int i = 0; i < 300; i++) begin
      run_txn(1'b0, 32'h3000_0200, 32'h0, 4'hF, -1, 32'h0, n, ok);
      take_rsp();
    end
    tests++; if (err_count !== 8'd255) begin fails++; $display("FAIL err_saturate: got %0d want 255", err_count); end
    tests++; if (txn_count !== 8'd1) begin fails++; $display("FAIL txn_after_errs: got %0d want 1", txn_count); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_adr = '0; bus.req_dat = '0; bus.req_sel = '0;
    bus.rsp_ready = 1'b0; bus.wbm_dat_i = '0; bus.wbm_ack_i = 1'b0;
    #1;
    tick();
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
